// File: rtl/fluorescence_acq_sequencer.sv
// fluorescence_acq_sequencer: frame scheduler for settle, integrate, snapshot and handshaked bin readout
module fluorescence_acq_sequencer #(
    parameter int SETTLE_CYCLES = 5000,
    parameter int NUM_BINS = 40,
    parameter int BIN_W = 6
) (
    input  logic             clock_50_mhz,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      integration_cycles,
    input  logic [15:0]      num_frames,
    input  logic             dark_interleave,
    output logic             light_enable,
    output logic             count_enable,
    output logic             snapshot_strobe,
    output logic             frame_is_dark,
    output logic             bin_valid,
    input  logic             bin_ready,
    output logic [BIN_W-1:0] bin_index,
    output logic             bin_clear,
    output logic             busy,
    output logic [15:0]      frame_count,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, SETTLE, INTEGRATE, LATCH, READOUT} state_t;
    localparam bit SKIP = SETTLE_CYCLES == 0;
    localparam logic [31:0] SETTLE_LAST = SKIP ? 32'd0 : 32'(SETTLE_CYCLES - 1);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
    localparam state_t FIRST = SKIP ? INTEGRATE : SETTLE;
    state_t state;
    logic [31:0] cnt, int_last, int_first;
    logic [15:0] run_frames, fc_next;
    logic run_dark, dark_next;
    assign bin_clear = bin_valid & bin_ready & ~abort & ~reset;
    assign fc_next = frame_count == 16'hffff ? frame_count : frame_count + 16'd1;
    assign dark_next = run_dark & ~frame_is_dark;
    // cnt holds remaining cycles minus one, so a zero length integrates once
    assign int_first = integration_cycles == 32'd0 ? 32'd0 : integration_cycles - 32'd1;
    always_ff @(posedge clock_50_mhz) begin
        if (reset || abort) begin
            state <= IDLE;
            light_enable <= 1'b0;
            count_enable <= 1'b0;
            snapshot_strobe <= 1'b0;
            frame_is_dark <= 1'b0;
            bin_valid <= 1'b0;
            bin_index <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            if (reset) frame_count <= 16'd0;
        end else begin
            snapshot_strobe <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= FIRST;
                    cnt <= SKIP ? int_first : SETTLE_LAST;
                    int_last <= int_first;
                    run_frames <= num_frames;
                    run_dark <= dark_interleave;
                    busy <= 1'b1;
                    frame_count <= 16'd0;
                    frame_is_dark <= 1'b0;
                    light_enable <= 1'b1;
                    count_enable <= SKIP;
                end
                SETTLE: if (cnt == 32'd0) begin
                    state <= INTEGRATE;
                    cnt <= int_last;
                    count_enable <= 1'b1;
                end else cnt <= cnt - 32'd1;
                INTEGRATE: if (cnt == 32'd0) begin
                    state <= LATCH;
                    count_enable <= 1'b0;
                    light_enable <= 1'b0;
                    snapshot_strobe <= 1'b1;
                end else cnt <= cnt - 32'd1;
                LATCH: begin
                    state <= READOUT;
                    bin_valid <= 1'b1;
                    bin_index <= '0;
                end
                READOUT: if (bin_ready) begin
                    if (bin_index == LAST_BIN) begin
                        bin_valid <= 1'b0;
                        bin_index <= '0;
                        frame_count <= fc_next;
                        if (run_frames != 16'd0 && fc_next == run_frames) begin
                            state <= IDLE;
                            done <= 1'b1;
                            busy <= 1'b0;
                            frame_is_dark <= 1'b0;
                        end else begin
                            state <= FIRST;
                            cnt <= SKIP ? int_last : SETTLE_LAST;
                            count_enable <= SKIP;
                            frame_is_dark <= dark_next;
                            light_enable <= ~dark_next;
                        end
                    end else bin_index <= bin_index + BIN_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fluorescence_acq_sequencer.md
Name: fluorescence_acq_sequencer

Overview:
Frame-level controller for the photon-counting lock-in datapath. It sequences each acquisition frame through four steps: light settle, gated counting, counter snapshot, and a handshaked readout/clear of the gated-waveform histogram bins. It optionally interleaves dark frames for background subtraction. It replaces free-running integration and readout timers with one start/abort-controlled scheduler.

Parameters:
SETTLE_CYCLES, 5000, cycles with light in the frame state before counting opens (0 = skip SETTLE)
NUM_BINS, 40, number of waveform histogram bins read out per frame (2..64)
BIN_W, 6, width of bin_index (ceil(log2(NUM_BINS)))

Ports:
clock_50_mhz  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  single-cycle request to begin a run; honoured only in IDLE
abort  in  1  terminate the run; takes priority over start
integration_cycles  in  32  counting-window length; latched on start; 0 is treated as 1
num_frames  in  16  frames per run; latched on start; 0 = continuous
dark_interleave  in  1  latched on start; 1 = alternate lit/dark frames, first frame lit
light_enable  out  1  light-source modulation enable
count_enable  out  1  gates PMT pulse accumulation and waveform writes
snapshot_strobe  out  1  one-cycle pulse; datapath latches I/Q counters, then clears accumulators
frame_is_dark  out  1  1 while the current frame is dark; valid throughout the frame
bin_valid  out  1  bin_index is presented for readout
bin_ready  in  1  consumer accepts the current bin
bin_index  out  BIN_W  waveform bin being read
bin_clear  out  1  = bin_valid & bin_ready; datapath zeroes bin_index that cycle
busy  out  1  high in any state other than IDLE
frame_count  out  16  frames completed in the current run
done  out  1  one-cycle pulse when a finite run completes

Behaviour:
- Reset: state = IDLE. light_enable, count_enable, snapshot_strobe, frame_is_dark, bin_valid, busy, done = 0. bin_index = 0. frame_count = 0. All outputs are registered except bin_clear.
- States: IDLE -> SETTLE -> INTEGRATE -> LATCH -> READOUT -> (SETTLE | IDLE).
- IDLE: if start=1 and abort=0 at edge T, then at T+1: state = SETTLE (or INTEGRATE if SETTLE_CYCLES = 0), busy = 1, frame_count = 0, frame_is_dark = 0, light_enable = 1. Inputs are latched at T.
- SETTLE: lasts exactly SETTLE_CYCLES cycles. light_enable = !frame_is_dark. count_enable = 0.
- INTEGRATE: count_enable = 1 for exactly max(integration_cycles, 1) cycles. Uses a 32-bit down-counter. light_enable is unchanged from SETTLE.
- LATCH: exactly 1 cycle. snapshot_strobe = 1, count_enable = 0, light_enable = 0.
- READOUT: bin_valid = 1, bin_index starts at 0.
  - On each bin_valid & bin_ready: bin_clear = 1 in the same cycle, then bin_index increments.
  - With bin_ready = 0: bin_index and bin_valid hold; bin_clear = 0. There is no timeout.
  - Acceptance of bin NUM_BINS-1 ends the frame. Next cycle: bin_valid = 0, bin_index = 0, frame_count + 1.
    - If num_frames != 0 and the new frame_count == num_frames: go to IDLE, pulse done, busy = 0.
    - Otherwise: go to SETTLE (or INTEGRATE); frame_is_dark toggles if dark_interleave, else stays 0.
- count_enable is never high in READOUT. The waveform is never written while it is being cleared.
- frame_count saturates at 65535 in continuous mode. The run continues.
- abort = 1 in any non-IDLE state: at the next cycle, IDLE with all outputs at reset values except frame_count, which holds. No snapshot_strobe, no done, no bin_clear in the abort cycle (bin_clear = 0 when abort = 1).
- start while busy: ignored. start and abort in the same IDLE cycle: stays IDLE.
- Inputs changing mid-run: no effect until the next start.
- Reset mid-run: identical to abort, and frame_count is cleared.

Test Plan:
1. Reset asserted 3 cycles with start = 1 -> all outputs 0, busy = 0. After release with start = 0, stays IDLE.
2. SETTLE_CYCLES = 4, NUM_BINS = 4, integration_cycles = 10, num_frames = 1, bin_ready = 1, start at T -> light_enable high T+1..T+14, count_enable high T+5..T+14, snapshot_strobe at T+15, bin_clear at T+16..T+19 with indices 0..3, done at T+20, frame_count = 1, busy low from T+20.
3. dark_interleave = 1, num_frames = 4 -> frame_is_dark 0, 1, 0, 1 across frames. light_enable high only in frames 1 and 3. 4 snapshot_strobes, a single done, frame_count = 4.
4. bin_ready held low 7 cycles at bin_index = 2 -> bin_index stays 2, bin_valid stays 1, bin_clear stays 0. Readout resumes at index 2 when bin_ready rises.
5. abort at the 5th INTEGRATE cycle of frame 2 -> next cycle count_enable = 0, light_enable = 0, busy = 0, frame_count = 1, no snapshot_strobe or done afterwards.
6. integration_cycles = 0, num_frames = 0 -> count_enable high exactly 1 cycle per frame. A start pulse issued mid-run is ignored. The run continues past 3 frames until abort.
